// File: rtl/alu_issue_stage_if.sv
// Decoded-instruction handshake between the MicroUAZ8 decoder (master)
// and the ALU issue stage (slave).
interface alu_issue_stage_if #(
  parameter int DW = 8,
  parameter int AW = 3
);
  logic          instr_valid;
  logic          instr_ready;
  logic [2:0]    instr_op;
  logic [AW-1:0] instr_rd;
  logic [AW-1:0] instr_rs;
  logic [AW-1:0] instr_rt;
  logic          instr_imm_en;
  logic [DW-1:0] instr_imm;

  modport master (
    output instr_valid, instr_op, instr_rd, instr_rs, instr_rt, instr_imm_en, instr_imm,
    input  instr_ready
  );

  modport slave (
    input  instr_valid, instr_op, instr_rd, instr_rs, instr_rt, instr_imm_en, instr_imm,
    output instr_ready
  );
endinterface

// File: rtl/alu_issue_stage.sv
// Operand-issue and write-back stage around the MicroUAZ8 8-bit ALU: owns the
// register file and flag register, issues one instruction every three cycles.
module alu_issue_stage #(
  parameter int            DW       = 8,
  parameter int            AW       = 3,
  parameter logic [DW-1:0] REG_INIT = {DW{1'b0}}
) (
  input  logic                clk,
  input  logic                rst,
  alu_issue_stage_if.slave    instr_if,
  output logic [DW-1:0]       alu_rx_o,
  output logic [DW-1:0]       alu_ry_o,
  output logic [2:0]          alu_sel_o,
  input  logic [DW-1:0]       alu_r0_i,
  input  logic [2:0]          alu_flags_i,
  output logic [2:0]          flags_q_o,
  output logic                wb_done_o,
  input  logic [AW-1:0]       dbg_addr_i,
  output logic [DW-1:0]       dbg_data_o
);

  localparam int DEPTH = 2 ** AW;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OPER = 2'd1,
    WB   = 2'd2
  } state_e;

  state_e        state_q;
  logic          ready_q;
  logic          wb_done_q;
  logic [DW-1:0] rx_q;
  logic [DW-1:0] ry_q;
  logic [2:0]    sel_q;
  logic [AW-1:0] rd_q;
  logic [2:0]    flags_q;
  logic [DW-1:0] regs_q [DEPTH];

  // Outputs are registered so the ALU sees stable operands for all of OPER and WB.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      ready_q   <= 1'b1;
      wb_done_q <= 1'b0;
      rx_q      <= '0;
      ry_q      <= '0;
      sel_q     <= '0;
      rd_q      <= '0;
      flags_q   <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (instr_if.instr_valid) begin
            rx_q    <= regs_q[instr_if.instr_rs];
            ry_q    <= instr_if.instr_imm_en ? instr_if.instr_imm : regs_q[instr_if.instr_rt];
            sel_q   <= instr_if.instr_op;
            rd_q    <= instr_if.instr_rd;
            ready_q <= 1'b0;
            state_q <= OPER;
          end
        end
        OPER: begin
          wb_done_q <= 1'b1;
          state_q   <= WB;
        end
        WB: begin
          flags_q   <= alu_flags_i;
          wb_done_q <= 1'b0;
          ready_q   <= 1'b1;
          state_q   <= IDLE;
        end
        default: begin
          wb_done_q <= 1'b0;
          ready_q   <= 1'b1;
          state_q   <= IDLE;
        end
      endcase
    end
  end

  // A reset during OPER or WB lands here before the WB edge, so no write escapes.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        regs_q[i] <= REG_INIT;
      end
    end else if (state_q == WB) begin
      regs_q[rd_q] <= alu_r0_i;
    end
  end

  assign instr_if.instr_ready = ready_q;
  assign alu_rx_o             = rx_q;
  assign alu_ry_o             = ry_q;
  assign alu_sel_o            = sel_q;
  assign flags_q_o            = flags_q;
  assign wb_done_o            = wb_done_q;
  assign dbg_data_o           = regs_q[dbg_addr_i];

endmodule

// File: tb/tb_alu_issue_stage.sv
// Bench for alu_issue_stage: a behavioural ALU closes the loop, and a register/flag
// model predicts operands, write-back timing and results for directed and random instructions.
module tb_alu_issue_stage;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] aluRx;
  logic [7:0] aluRy;
  logic [2:0] aluSel;
  logic [7:0] aluR0;
  logic [2:0] aluFlags;
  logic [2:0] flagsQ;
  logic       wbDone;
  logic [2:0] dbgAddr;
  logic [7:0] dbgData;

  int vectors     = 0;
  int miscompares = 0;
  int cyc         = 0;
  int lastAccept  = 0;
  bit prevHeld    = 1'b0;

  logic [7:0] modelRegs [8];
  logic [2:0] modelFlags;

  alu_issue_stage_if #(.DW(8), .AW(3)) instrIf ();

  alu_issue_stage #(.DW(8), .AW(3), .REG_INIT(8'h00)) dut (
    .clk         (clk),
    .rst         (rst),
    .instr_if    (instrIf),
    .alu_rx_o    (aluRx),
    .alu_ry_o    (aluRy),
    .alu_sel_o   (aluSel),
    .alu_r0_i    (aluR0),
    .alu_flags_i (aluFlags),
    .flags_q_o   (flagsQ),
    .wb_done_o   (wbDone),
    .dbg_addr_i  (dbgAddr),
    .dbg_data_o  (dbgData)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Behavioural ALU: returns {sign, carry/borrow, zero, result}.
  function automatic logic [10:0] aluFn(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
    logic [8:0] wide;
    logic [7:0] r;
    logic       c;
    wide = 9'd0;
    r    = 8'd0;
    c    = 1'b0;
    case (op)
      3'd0: begin wide = {1'b0, a} + {1'b0, b}; r = wide[7:0]; c = wide[8]; end
      3'd1: begin wide = {1'b0, a} - {1'b0, b}; r = wide[7:0]; c = wide[8]; end
      3'd2: r = a & b;
      3'd3: r = a | b;
      3'd4: r = a ^ b;
      3'd5: r = (b >= 8'd8) ? 8'd0 : (a << b);
      3'd6: r = (b >= 8'd8) ? 8'd0 : (a >> b);
      default: r = b;
    endcase
    return {r[7], c, (r == 8'd0), r};
  endfunction

  always_comb {aluFlags, aluR0} = aluFn(aluSel, aluRx, aluRy);

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    vectors++;
    assert (observed === expected) else begin
      miscompares++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // Issues one instruction from IDLE and checks its OPER, WB and post-WB cycles.
  task automatic applyStimulus(input logic [2:0] op, input logic [2:0] rd, input logic [2:0] rs,
                               input logic [2:0] rt, input logic immEn, input logic [7:0] imm,
                               input bit holdValid);
    logic [7:0]  expRx;
    logic [7:0]  expRy;
    logic [7:0]  oldRd;
    logic [10:0] res;
    instrIf.instr_valid  = 1'b1;
    instrIf.instr_op     = op;
    instrIf.instr_rd     = rd;
    instrIf.instr_rs     = rs;
    instrIf.instr_rt     = rt;
    instrIf.instr_imm_en = immEn;
    instrIf.instr_imm    = imm;
    expRx = modelRegs[rs];
    expRy = immEn ? imm : modelRegs[rt];
    res   = aluFn(op, expRx, expRy);
    oldRd = modelRegs[rd];

    @(posedge clk);
    @(negedge clk);
    if (prevHeld) checkOutput("accept_spacing", cyc - lastAccept, 32'd3);
    lastAccept = cyc;
    checkOutput("oper_ready", instrIf.instr_ready, 1'b0);
    checkOutput("oper_wb_done", wbDone, 1'b0);
    checkOutput("oper_rx", aluRx, expRx);
    checkOutput("oper_ry", aluRy, expRy);
    checkOutput("oper_sel", aluSel, op);
    instrIf.instr_valid  = holdValid;
    instrIf.instr_op     = 3'($urandom);
    instrIf.instr_rd     = 3'($urandom);
    instrIf.instr_rs     = 3'($urandom);
    instrIf.instr_rt     = 3'($urandom);
    instrIf.instr_imm_en = 1'($urandom);
    instrIf.instr_imm    = 8'($urandom);

    @(negedge clk);
    dbgAddr = rd;
    #1;
    checkOutput("wb_ready", instrIf.instr_ready, 1'b0);
    checkOutput("wb_done_pulse", wbDone, 1'b1);
    checkOutput("wb_rx_stable", aluRx, expRx);
    checkOutput("wb_dbg_old", dbgData, oldRd);

    @(negedge clk);
    #1;
    modelRegs[rd] = res[7:0];
    modelFlags    = res[10:8];
    checkOutput("idle_ready", instrIf.instr_ready, 1'b1);
    checkOutput("idle_wb_done", wbDone, 1'b0);
    checkOutput("result_reg", dbgData, modelRegs[rd]);
    checkOutput("result_flags", flagsQ, modelFlags);
    prevHeld = holdValid;
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    rst                  = 1'b1;
    dbgAddr              = 3'd0;
    instrIf.instr_valid  = 1'b0;
    instrIf.instr_op     = 3'd0;
    instrIf.instr_rd     = 3'd0;
    instrIf.instr_rs     = 3'd0;
    instrIf.instr_rt     = 3'd0;
    instrIf.instr_imm_en = 1'b0;
    instrIf.instr_imm    = 8'd0;
    for (int i = 0; i < 8; i++) modelRegs[i] = 8'h00;
    modelFlags = 3'b000;

    // Reset state.
    @(negedge clk);
    @(negedge clk);
    checkOutput("rst_ready", instrIf.instr_ready, 1'b1);
    checkOutput("rst_wb_done", wbDone, 1'b0);
    checkOutput("rst_rx", aluRx, 8'h00);
    checkOutput("rst_ry", aluRy, 8'h00);
    checkOutput("rst_sel", aluSel, 3'd0);
    rst = 1'b0;
    @(negedge clk);
    checkOutput("rel_ready", instrIf.instr_ready, 1'b1);
    checkOutput("rel_flags", flagsQ, 3'b000);
    for (int i = 0; i < 8; i++) begin
      dbgAddr = 3'(i);
      #1;
      checkOutput("rel_dbg", dbgData, 8'h00);
    end

    // ADD rd=1 rs=0 imm=5.
    applyStimulus(3'd0, 3'd1, 3'd0, 3'd0, 1'b1, 8'h05, 1'b0);
    checkOutput("t2_reg1", dbgData, 8'h05);
    checkOutput("t2_flags", flagsQ, 3'b000);

    // reg2 = 0xFF via immediate, then ADD rd=3 rs=1 rt=2 carries out.
    applyStimulus(3'd0, 3'd2, 3'd0, 3'd0, 1'b1, 8'hFF, 1'b0);
    applyStimulus(3'd0, 3'd3, 3'd1, 3'd2, 1'b0, 8'h00, 1'b0);
    checkOutput("t3_reg3", dbgData, 8'h04);
    checkOutput("t3_flags", flagsQ, 3'b010);

    // SUB rd=4 rs=1 rt=1 gives zero.
    applyStimulus(3'd1, 3'd4, 3'd1, 3'd1, 1'b0, 8'h00, 1'b0);
    checkOutput("t4_reg4", dbgData, 8'h00);
    checkOutput("t4_flags", flagsQ, 3'b001);

    // Valid held high: back-to-back accepts, second reads the first's result.
    applyStimulus(3'd0, 3'd6, 3'd1, 3'd0, 1'b1, 8'h03, 1'b1);
    applyStimulus(3'd1, 3'd7, 3'd6, 3'd2, 1'b0, 8'h00, 1'b0);

    // Randomized instructions, occasionally chained.
    for (int n = 0; n < 40; n++) begin
      applyStimulus(3'($urandom), 3'($urandom), 3'($urandom), 3'($urandom),
                    1'($urandom), 8'($urandom), (n != 39) && ($urandom_range(0, 1) == 1));
    end

    // Reset during OPER aborts the instruction.
    instrIf.instr_valid  = 1'b1;
    instrIf.instr_op     = 3'd0;
    instrIf.instr_rd     = 3'd5;
    instrIf.instr_rs     = 3'd1;
    instrIf.instr_rt     = 3'd0;
    instrIf.instr_imm_en = 1'b1;
    instrIf.instr_imm    = 8'h10;
    @(posedge clk);
    @(negedge clk);
    checkOutput("t6_accepted", instrIf.instr_ready, 1'b0);
    instrIf.instr_valid = 1'b0;
    rst = 1'b1;
    #1;
    checkOutput("t6_ready", instrIf.instr_ready, 1'b1);
    checkOutput("t6_flags", flagsQ, 3'b000);
    checkOutput("t6_rx", aluRx, 8'h00);
    #2;
    rst = 1'b0;
    for (int i = 0; i < 8; i++) modelRegs[i] = 8'h00;
    modelFlags = 3'b000;
    prevHeld   = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      checkOutput("t6_no_wb_done", wbDone, 1'b0);
      checkOutput("t6_idle", instrIf.instr_ready, 1'b1);
    end
    for (int i = 0; i < 8; i++) begin
      dbgAddr = 3'(i);
      #1;
      checkOutput("t6_dbg", dbgData, modelRegs[i]);
    end
    checkOutput("t6_flags_after", flagsQ, 3'b000);

    // Function restored after the abort.
    applyStimulus(3'd4, 3'd5, 3'd0, 3'd0, 1'b1, 8'hA5, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
